integral_image_stream: RTL and testbench

Streaming integral-image generator that sits directly upstream of the window standard-deviation and scan-window stages. It accepts raw 8-bit pixels in raster order, one per handshake, and emits the matching integral-image value and squared-integral-image value for each pixel position. The scan-window buffers consume these values, so the sums at window corners yield window sums and sums of squares. A single line buffer of previous-row integrals is held internally, so no full frame store is needed.

---
 rtl/integral_image_stream_if.sv | 33 +++
 rtl/integral_image_stream.sv | 105 ++++++++++
 tb/tb_integral_image_stream.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/integral_image_stream_if.sv
// Pixel-in / integral-out handshake bundle for integral_image_stream.
interface integral_image_stream_if #(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240,
   parameter int PIX_W = 8
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] in_pix;
   logic             in_sof;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_ii;
   logic [31:0]      out_ii_sq;
   logic [RW-1:0]    out_row;
   logic [CW-1:0]    out_col;
   logic             out_eof;

   // Block side: consumes pixels, produces integrals.
   modport slave (
      input  in_valid, in_pix, in_sof, out_ready,
      output in_ready, out_valid, out_ii, out_ii_sq, out_row, out_col, out_eof
   );

   // Environment side: produces pixels, consumes integrals.
   modport master (
      output in_valid, in_pix, in_sof, out_ready,
      input  in_ready, out_valid, out_ii, out_ii_sq, out_row, out_col, out_eof
   );
endinterface

// File: rtl/integral_image_stream.sv
// Streaming integral-image / squared-integral-image generator.
// One pixel per accept, one-cycle latency, single output register.
// A line buffer holds the previous row's integrals; row 0 never reads it.
module integral_image_stream #(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240,
   parameter int PIX_W = 8
) (
   input logic                    clock,
   input logic                    reset_n,
   integral_image_stream_if.slave s
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [31:0]   row_sum_q;
   logic [31:0]   row_sum_sq_q;
   logic [31:0]   lb_ii [IMG_W];
   logic [31:0]   lb_sq [IMG_W];

   logic          out_valid_q;
   logic [31:0]   out_ii_q;
   logic [31:0]   out_ii_sq_q;
   logic [RW-1:0] out_row_q;
   logic [CW-1:0] out_col_q;
   logic          out_eof_q;

   logic          accept;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic          last_col;
   logic          last_row;
   logic [31:0]   pix32;
   logic [31:0]   row_sum_nx;
   logic [31:0]   row_sum_sq_nx;
   logic [31:0]   ii_nx;
   logic [31:0]   ii_sq_nx;

   assign s.in_ready  = !out_valid_q || s.out_ready;
   assign s.out_valid = out_valid_q;
   assign s.out_ii    = out_ii_q;
   assign s.out_ii_sq = out_ii_sq_q;
   assign s.out_row   = out_row_q;
   assign s.out_col   = out_col_q;
   assign s.out_eof   = out_eof_q;

   // Position of the pixel on the input (sof forces origin) and its integrals.
   always_comb begin
      accept        = s.in_valid && s.in_ready;
      cur_col       = s.in_sof ? '0 : col_q;
      cur_row       = s.in_sof ? '0 : row_q;
      last_col      = (cur_col == LAST_COL);
      last_row      = (cur_row == LAST_ROW);
      pix32         = 32'(s.in_pix);
      row_sum_nx    = ((cur_col == '0) ? '0 : row_sum_q) + pix32;
      row_sum_sq_nx = ((cur_col == '0) ? '0 : row_sum_sq_q) + pix32 * pix32;
      ii_nx         = ((cur_row == '0) ? '0 : lb_ii[cur_col]) + row_sum_nx;
      ii_sq_nx      = ((cur_row == '0) ? '0 : lb_sq[cur_col]) + row_sum_sq_nx;
   end

   // Counters, running row sums and the output register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col_q        <= '0;
         row_q        <= '0;
         row_sum_q    <= '0;
         row_sum_sq_q <= '0;
         out_valid_q  <= 1'b0;
         out_ii_q     <= '0;
         out_ii_sq_q  <= '0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_eof_q    <= 1'b0;
      end else if (accept) begin
         row_sum_q    <= row_sum_nx;
         row_sum_sq_q <= row_sum_sq_nx;
         col_q        <= last_col ? '0 : cur_col + CW'(1);
         if (last_col) begin
            row_q <= last_row ? '0 : cur_row + RW'(1);
         end else begin
            row_q <= cur_row;
         end
         out_valid_q <= 1'b1;
         out_ii_q    <= ii_nx;
         out_ii_sq_q <= ii_sq_nx;
         out_row_q   <= cur_row;
         out_col_q   <= cur_col;
         out_eof_q   <= last_row && last_col;
      end else if (s.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Line buffer: read-before-write at the current column on every accept.
   always_ff @(posedge clock) begin
      if (accept) begin
         lb_ii[cur_col] <= ii_nx;
         lb_sq[cur_col] <= ii_sq_nx;
      end
   end
endmodule

// File: tb/tb_integral_image_stream.sv
// Self-checking bench for integral_image_stream: a 4x3 instance checked every
// cycle against a rectangle-sum model, and a default-size instance for wrap.
module tb_integral_image_stream;
   typedef struct {
      logic [31:0] ii;
      logic [31:0] sq;
      int unsigned row;
      int unsigned col;
      logic        eof;
   } rec_t;

   logic clock;
   logic reset_n;
   int   checks;
   int   failures;

   integral_image_stream_if #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) sif ();
   integral_image_stream_if #(.IMG_W(320), .IMG_H(240), .PIX_W(8)) bif ();

   integral_image_stream #(.IMG_W(4), .IMG_H(3), .PIX_W(8)) dut_s (
      .clock(clock), .reset_n(reset_n), .s(sif.slave));
   integral_image_stream #(.IMG_W(320), .IMG_H(240), .PIX_W(8)) dut_b (
      .clock(clock), .reset_n(reset_n), .s(bif.slave));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------- model + compare process (small instance) ----------------
   rec_t        exp_q[$];
   rec_t        log_q[$];
   rec_t        held;
   rec_t        cur;
   rec_t        nr;
   bit          held_valid;
   int unsigned m_r, m_c;
   int unsigned pixm [3][4];
   logic [31:0] ms, mq;

   always @(negedge clock) begin
      cur.ii  = sif.out_ii;
      cur.sq  = sif.out_ii_sq;
      cur.row = 32'(sif.out_row);
      cur.col = 32'(sif.out_col);
      cur.eof = sif.out_eof;
      if (!reset_n) begin
         exp_q.delete();
         m_r = 0;
         m_c = 0;
         held_valid = 1'b0;
         chk("rst_valid", 64'(sif.out_valid), 64'd0);
      end else begin
         chk("valid", 64'(sif.out_valid), 64'(exp_q.size() != 0));
         chk("ready", 64'(sif.in_ready), 64'(!sif.out_valid || sif.out_ready));
         if (held_valid && sif.out_valid) begin
            chk("stable_ii", {cur.ii, cur.sq}, {held.ii, held.sq});
            chk("stable_pos", {cur.row[15:0], cur.col[15:0], 31'd0, cur.eof},
                {held.row[15:0], held.col[15:0], 31'd0, held.eof});
         end
         if (sif.out_valid && exp_q.size() != 0) begin
            chk("ii", 64'(cur.ii), 64'(exp_q[0].ii));
            chk("ii_sq", 64'(cur.sq), 64'(exp_q[0].sq));
            chk("row", 64'(cur.row), 64'(exp_q[0].row));
            chk("col", 64'(cur.col), 64'(exp_q[0].col));
            chk("eof", 64'(cur.eof), 64'(exp_q[0].eof));
         end
         if (sif.out_valid && sif.out_ready) begin
            log_q.push_back(cur);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            held_valid = 1'b0;
         end else if (sif.out_valid) begin
            held = cur;
            held_valid = 1'b1;
         end
         if (sif.in_valid && sif.in_ready) begin
            if (sif.in_sof) begin
               m_r = 0;
               m_c = 0;
            end
            pixm[m_r][m_c] = 32'(sif.in_pix);
            ms = '0;
            mq = '0;
            for (int i = 0; i <= int'(m_r); i++)
               for (int j = 0; j <= int'(m_c); j++) begin
                  ms = ms + pixm[i][j];
                  mq = mq + pixm[i][j] * pixm[i][j];
               end
            nr.ii  = ms;
            nr.sq  = mq;
            nr.row = m_r;
            nr.col = m_c;
            nr.eof = (m_r == 2) && (m_c == 3);
            exp_q.push_back(nr);
            if (m_c == 3) begin
               m_c = 0;
               m_r = (m_r == 2) ? 0 : m_r + 1;
            end else begin
               m_c = m_c + 1;
            end
         end
      end
   end

   // ---------------- stimulus helpers (called at posedge+1) ----------------
   task automatic send(input logic [7:0] p, input logic sof, input bit rnd);
      int unsigned n;
      bit acc;
      if (rnd) begin
         n = 0;
         while ($urandom_range(1) == 0 && n < 8) begin
            sif.in_valid  = 1'b0;
            sif.out_ready = 1'($urandom_range(1));
            @(posedge clock); #1;
            n++;
         end
      end
      sif.in_valid = 1'b1;
      sif.in_pix   = p;
      sif.in_sof   = sof;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
         if (n == 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=stalled required=accept");
            $fatal(1, "accept timeout");
         end
         sif.out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
         @(negedge clock);
         acc = sif.in_ready;
         @(posedge clock); #1;
         n++;
      end
      sif.in_valid = 1'b0;
      sif.in_sof   = 1'b0;
   endtask

   task automatic drain();
      int unsigned n;
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clock); #1;
         n++;
      end while (sif.out_valid && n < 20);
      chk("drain", 64'(sif.out_valid), 64'd0);
      @(posedge clock); #1;
   endtask

   task automatic chk_rec(input string name, input int unsigned idx, input logic [31:0] ii,
                          input logic [31:0] sq, input int unsigned row, input int unsigned col,
                          input logic eof);
      if (idx >= log_q.size()) begin
         chk({name, "_present"}, 64'(log_q.size()), 64'(idx + 1));
      end else begin
         chk({name, "_ii"}, 64'(log_q[idx].ii), 64'(ii));
         chk({name, "_sq"}, 64'(log_q[idx].sq), 64'(sq));
         chk({name, "_pos"}, {32'(log_q[idx].row), 32'(log_q[idx].col)}, {32'(row), 32'(col)});
         chk({name, "_eof"}, 64'(log_q[idx].eof), 64'(eof));
      end
   endtask

   // ---------------- directed sequence ----------------
   int unsigned b1, b2, b3, b4, b5;

   initial begin
      checks = 0;
      failures = 0;
      reset_n = 1'b0;
      sif.in_valid = 1'b0; sif.in_pix = '0; sif.in_sof = 1'b0; sif.out_ready = 1'b1;
      bif.in_valid = 1'b0; bif.in_pix = '0; bif.in_sof = 1'b0; bif.out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_out_valid", 64'(sif.out_valid), 64'd0);
      chk("reset_in_ready", 64'(sif.in_ready), 64'd1);
      chk("reset_payload", {sif.out_ii, sif.out_ii_sq}, 64'd0);
      chk("reset_pos", {59'd0, sif.out_row, sif.out_col, sif.out_eof}, 64'd0);
      chk("reset_big", {62'd0, bif.out_valid, bif.in_ready}, 64'd1);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // all ones, 4x3
      b1 = log_q.size();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) send(8'd1, (r == 0 && c == 0), 1'b0);
      drain();
      chk_rec("ones_r1c2", b1 + 6, 32'd6, 32'd6, 1, 2, 1'b0);
      chk_rec("ones_last", b1 + 11, 32'd12, 32'd12, 2, 3, 1'b1);

      // ramp, no stall
      b2 = log_q.size();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) send(8'(c + 4 * r), (r == 0 && c == 0), 1'b0);
      drain();
      chk_rec("ramp_last", b2 + 11, 32'd66, 32'd506, 2, 3, 1'b1);

      // ramp, two frames, random valid/ready
      b3 = log_q.size();
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) send(8'(c + 4 * r), (f == 0 && r == 0 && c == 0), 1'b1);
      drain();
      chk("stall_count", 64'(log_q.size() - b3), 64'd24);
      for (int j = 0; j < 24; j++) begin
         if (b3 + j < log_q.size()) begin
            chk("stall_vs_nostall_ii", {log_q[b3 + j].ii, log_q[b3 + j].sq},
                {log_q[b2 + (j % 12)].ii, log_q[b2 + (j % 12)].sq});
            chk("stall_vs_nostall_pos", {32'(log_q[b3 + j].row), 32'(log_q[b3 + j].col)},
                {32'(log_q[b2 + (j % 12)].row), 32'(log_q[b2 + (j % 12)].col)});
         end
      end

      // sof mid-frame at (1,2)
      b4 = log_q.size();
      for (int k = 0; k < 6; k++) send(8'd1, (k == 0), 1'b0);
      send(8'd5, 1'b1, 1'b0);
      for (int k = 0; k < 11; k++) send(8'd1, 1'b0, 1'b0);
      drain();
      chk_rec("sof_origin", b4 + 6, 32'd5, 32'd25, 0, 0, 1'b0);
      chk_rec("sof_next", b4 + 7, 32'd6, 32'd26, 0, 1, 1'b0);
      chk_rec("sof_last", b4 + 17, 32'd16, 32'd36, 2, 3, 1'b1);

      // asynchronous reset mid-frame
      for (int k = 0; k < 5; k++) send(8'(k), (k == 0), 1'b0);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_reset_valid", 64'(sif.out_valid), 64'd0);
      @(negedge clock);
      @(posedge clock); #1;
      reset_n = 1'b1;
      b5 = log_q.size();
      send(8'd7, 1'b0, 1'b0);
      send(8'd3, 1'b0, 1'b0);
      drain();
      chk_rec("post_reset_first", b5, 32'd7, 32'd49, 0, 0, 1'b0);
      chk_rec("post_reset_second", b5 + 1, 32'd10, 32'd58, 0, 1, 1'b0);

      // default size, all 255: ii_sq wraps modulo 2^32
      for (int i = 0; i < 76800; i++) begin
         bif.in_valid = 1'b1;
         bif.in_pix   = 8'd255;
         bif.in_sof   = (i == 0);
         @(posedge clock); #1;
         if (i == 0) begin
            chk("big_first", {bif.out_ii, bif.out_ii_sq}, {32'd255, 32'd65025});
            chk("big_first_pos", {47'd0, bif.out_row, bif.out_col}, 64'd0);
         end
      end
      bif.in_valid = 1'b0;
      bif.in_sof   = 1'b0;
      chk("big_last_valid", 64'(bif.out_valid), 64'd1);
      chk("big_last_ii", 64'(bif.out_ii), 64'd19584000);
      chk("big_last_ii_sq", 64'(bif.out_ii_sq), 64'd698952704);
      chk("big_last_pos", {47'd0, bif.out_row, bif.out_col}, {47'd0, 8'd239, 9'd319});
      chk("big_last_eof", 64'(bif.out_eof), 64'd1);
      @(posedge clock); #1;
      chk("big_drop_valid", 64'(bif.out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
